// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short-press / long-press / double-click pulses.
// Latency: every event is a registered 1-cycle pulse after the deciding sample; no backpressure.
// Macro BUTTON_DCLICK_EN enables double-click detection (gap wait + second press).
module button_event_decoder #(
    parameter int LONG_CNT   = 8,
    parameter int DCLICK_GAP = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    if (LONG_CNT < 2) begin : g_long_chk
        $error("LONG_CNT must be at least 2");
    end
    if (DCLICK_GAP < 1) begin : g_gap_chk
        $error("DCLICK_GAP must be at least 1");
    end
    if ((64'(1) << CNT_W) <= 64'(LONG_CNT) || (64'(1) << CNT_W) <= 64'(DCLICK_GAP)) begin : g_w_chk
        $error("CNT_W too narrow for LONG_CNT/DCLICK_GAP");
    end

`ifdef BUTTON_DCLICK_EN
    typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, WAIT_GAP, PRESS2} state_t;
    localparam logic [CNT_W-1:0] GAP_V = CNT_W'(DCLICK_GAP);
`else
    typedef enum logic [1:0] {IDLE, PRESS1, LONG_HELD} state_t;
`endif

    localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             prev;

    // Saturating increment: the counter never wraps back to a small value.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + ONE;

`ifdef BUTTON_DCLICK_EN
    logic dclick_q;
    assign double_click = dclick_q;
`else
    assign double_click = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prev        <= 1'b1;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            busy        <= 1'b0;
`ifdef BUTTON_DCLICK_EN
            dclick_q    <= 1'b0;
`endif
        end else begin
            prev        <= sig_in;
            short_press <= 1'b0;
            long_press  <= 1'b0;
`ifdef BUTTON_DCLICK_EN
            dclick_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sig_in && !prev) begin
                        state <= PRESS1;
                        cnt   <= ONE;
                        busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (sig_in) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == LONG_V) begin
                            long_press <= 1'b1;
                            state      <= LONG_HELD;
                        end
                    end else begin
`ifdef BUTTON_DCLICK_EN
                        // A one-sample window closes on the fall sample itself.
                        if (DCLICK_GAP == 1) begin
                            short_press <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            state <= WAIT_GAP;
                            cnt   <= ONE;
                        end
`else
                        short_press <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
`endif
                    end
                end
                LONG_HELD: begin
                    if (!sig_in) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef BUTTON_DCLICK_EN
                WAIT_GAP: begin
                    if (sig_in) begin
                        state <= PRESS2;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == GAP_V) begin
                            short_press <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
                    end
                end
                PRESS2: begin
                    if (!sig_in) begin
                        dclick_q <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced push-button level into discrete user events: short press, long press and double click. It sits directly downstream of the debouncer and consumes its clean `sig_out` level on its `sig_in` port. It emits single-cycle event pulses for the control FSMs.

## Interface
Parameters:
- `LONG_CNT`, default 8: number of consecutive high samples that qualify a long press; must be at least 2.
- `DCLICK_GAP`, default 4: number of consecutive low samples after a release that closes the double-click window; must be at least 1.
- `CNT_W`, default 16: counter width; must satisfy 2^CNT_W > max(LONG_CNT, DCLICK_GAP).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `sig_in`, in, 1: debounced button level; 1 = pressed.
- `short_press`, out, 1: one-cycle pulse for a completed short press.
- `long_press`, out, 1: one-cycle pulse when the hold reaches `LONG_CNT`.
- `double_click`, out, 1: one-cycle pulse on release of the second press.
- `busy`, out, 1: high whenever the FSM is not IDLE.

## Operation
- `prev` register holds `sig_in` from the previous edge.
  - Rise = `sig_in`=1 and `prev`=0.
  - Fall = `sig_in`=0 and `prev`=1.
- `cnt` register is `CNT_W` bits wide.
- FSM states and transitions:
  - IDLE:
    - rise → PRESS1, `cnt`=1.
    - Otherwise stay.
  - PRESS1:
    - `sig_in`=1 → `cnt`++.
    - If the incremented value equals `LONG_CNT` → pulse `long_press`, go to LONG_HELD.
    - `sig_in`=0 → WAIT_GAP, `cnt`=1.
  - LONG_HELD:
    - `sig_in`=0 → IDLE.
    - No further pulses are produced in this state, however long the hold.
  - WAIT_GAP:
    - `sig_in`=1 → PRESS2.
    - `sig_in`=0 → `cnt`++.
    - If the incremented value equals `DCLICK_GAP` → pulse `short_press`, go to IDLE.
    - Special case: `DCLICK_GAP`=1 fires on the entry sample itself.
  - PRESS2:
    - `sig_in`=0 → pulse `double_click`, go to IDLE.
    - The duration of the second press is irrelevant; there is no long press from PRESS2.
- Exactly one event is produced per gesture.
- `cnt` saturates and never wraps; the state transitions above guarantee it stays below 2^CNT_W.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt`=0, `prev`=1.
  - Because `prev` resets to 1, a button held through reset deassertion produces no event until it has been released and pressed again.
- Event outputs are registered. A condition sampled at edge k drives its pulse high for exactly the cycle between edge k and edge k+1.
- `busy` is registered and follows the state.
- Long press: the pulse follows the edge of the `LONG_CNT`-th consecutive high sample. The rise sample counts as sample 1.
- Short press: the pulse follows the edge of the `DCLICK_GAP`-th consecutive low sample. The fall sample counts as sample 1.
- Double click: the pulse follows the edge that samples the second release.
- Second press on the same edge the gap expires: the gap check wins.
  - Sample `DCLICK_GAP` is by definition low, so the window is closed.
  - A press sampled high at the next edge is a new rise from IDLE.
- Reset asserted mid-gesture: all outputs drop to 0 asynchronously and any pending event is discarded.

## Configuration
- Macro: `BUTTON_DCLICK_EN`.
- Defined:
  - Full behaviour as above.
- Undefined:
  - WAIT_GAP and PRESS2 are not compiled.
  - The PRESS1 release pulses `short_press` on the fall edge with 1-cycle latency and returns to IDLE.
  - `double_click` is tied to 0.
  - `DCLICK_GAP` is unused.

## Test plan
All scenarios use `LONG_CNT`=8 and `DCLICK_GAP`=4.
- Short press: high 3 samples, then low 10 → `short_press` pulses once after the 4th low sample; `long_press` and `double_click` stay 0.
- Long press: high 30 samples, then low → `long_press` pulses once after the 8th high sample; nothing else is emitted, and `busy` falls one cycle after the low sample.
- Double click: high 2, low 2, high 2, low → `double_click` pulses once after the second fall sample; no `short_press`.
- Gap boundary: high 2, low exactly 4, high 2, low 10 → `short_press` after low sample 4, then a second `short_press` for the new press; `double_click` stays 0.
- Reset cases:
  - `sig_in`=1 while `rst` is deasserted, held for 20 cycles → no events and `busy`=0; releasing and pressing again is then classified normally.
  - `rst` pulsed during WAIT_GAP → outputs go to 0 immediately and no `short_press` is emitted.
